inst_fetch_ctrl: RTL and testbench
==================================

# inst_fetch_ctrl

Instruction fetch controller that sequences the combinational instruction ROM and feeds the decode stage. It owns the fetch PC, drives the ROM address every cycle, and captures `{pc, inst}` pairs into a small prefetch FIFO. The FIFO drains to decode over a valid/ready handshake, and all in-flight fetches are flushed on a branch/jump redirect. It sits between the instruction ROM and the IF/ID pipeline register.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset; low 2 bits must be 0.
- `FIFO_DEPTH`, 2: prefetch entries; power of two, 2..8.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST_N` in 1: reset. One clock; reset is asynchronous and active-low.
- `rom_addr` out `ADDR_WIDTH`: byte address to the ROM; equals `fetch_pc`, combinational from the register.
- `rom_inst` in `DATA_WIDTH`: ROM word for `rom_addr`, valid in the same cycle.
- `halt` in 1: stop issuing new fetches; the FIFO still drains.
- `redirect_valid` in 1: flush the FIFO and restart at `redirect_pc`.
- `redirect_pc` in `ADDR_WIDTH`: new fetch target; bits [1:0] are ignored (forced to 0).
- `id_valid` out 1: FIFO head is valid.
- `id_ready` in 1: decode accepts the head this cycle.
- `id_inst` out `DATA_WIDTH`: head instruction.
- `id_pc` out `ADDR_WIDTH`: head PC.

## Operation
- State machine `state`: `S_BOOT`, `S_RUN`, `S_HALT`.
  - `S_BOOT`: entered on reset. No push. Next state is `S_RUN`, or `S_HALT` if `halt` is high.
  - `S_RUN`: pushes if `push_ok`. Goes to `S_HALT` when `halt`=1.
  - `S_HALT`: no push. Returns to `S_RUN` when `halt`=0.
- `pop` = `id_valid & id_ready`.
- `push_ok` = (`state`==`S_RUN`) & !`redirect_valid` & (`count`<`FIFO_DEPTH` | `pop`).
- On push: write `{fetch_pc, rom_inst}` at the tail, then `fetch_pc <= fetch_pc + 4`. The add is mod 2^32, so 32'hFFFF_FFFC wraps to 0.
- Simultaneous push and pop with a full FIFO is legal; `count` stays unchanged.
- Redirect (any state) has highest priority:
  - `count <= 0`, head/tail pointers reset, and `fetch_pc <= {redirect_pc[31:2], 2'b00}`.
  - Any pop in that cycle still completes, since decode sampled the head. No push in that cycle.
  - The state transition for `halt` still applies.
- `halt` and `redirect_valid` together: the PC is updated and the FIFO flushed; no fetch happens until `halt` drops.
- `id_valid` = (`count` != 0). `id_inst` and `id_pc` read the head entry and are driven 0 when `count`==0.
- Reset values:
  - `fetch_pc`=`RESET_PC`, `count`=0, pointers=0, `state`=`S_BOOT`.
  - `rom_addr`=`RESET_PC`, `id_valid`=0, `id_inst`=0, `id_pc`=0.
- `rom_inst` is sampled only on push cycles; its value is don't-care otherwise.
- Reset asserted mid-operation immediately clears all state and outputs (asynchronously); in-flight entries are lost.

## Timing
- Reset release at edge E0: `S_BOOT` during cycle E0→E1. First push at E2 captures `RESET_PC`; `id_valid`=1 after E2.
- Steady state with `id_ready`=1: one instruction per cycle; `id_pc` increments by 4 every cycle.
- Fetch-to-decode latency: the instruction addressed in cycle N appears at the head in cycle N+1.
- Redirect asserted in cycle T:
  - `rom_addr`=target in cycle T+1, push at the end of T+1, `id_valid` with the target in T+2.
  - `id_valid`=0 in cycle T+1.
- `id_ready`=0 backpressure: the FIFO fills in `FIFO_DEPTH` cycles; then `fetch_pc` and `rom_addr` hold.
- `halt` asserted in cycle T: the push in T still happens (`state` is still `S_RUN`); no pushes from T+1 onward.
- No combinational path from `id_ready` to `rom_addr`. `push_ok` depends on `id_ready` only for the tail write enable.

## Structure
- Widths come from the existing `config.vh` (`ADDR_WIDTH`, `DATA_WIDTH`, `ZeroWord`).
- Add `FetchBoot`/`FetchRun`/`FetchHalt` state encodings (2 bits) and `InstAlignMask` to `config.vh`.
- One sub-module, `fetch_fifo`: synchronous FIFO with flush, parameterised width (`ADDR_WIDTH`+`DATA_WIDTH`) and depth. It has `push`, `pop` and `flush` inputs and `count`/`full`/`empty` outputs.
- The FSM and PC logic stay in `inst_fetch_ctrl`.

## Test plan
- Reset release, `id_ready`=1, ROM holds word k = 32'h1000_0000+k → `id_pc` 0,4,8,… and `id_inst` 32'h1000_0000, 32'h1000_0001,… from cycle E2+1 with no bubbles.
- `id_ready`=0 for 6 cycles → `id_valid` held; FIFO full after 2 pushes; `rom_addr` frozen at 32'h8. On release, instructions resume in order with no loss or duplicate.
- Redirect to 32'h0000_0103 with the FIFO full → `rom_addr`=32'h100 next cycle; `id_valid`=0 for one cycle; next `id_pc`=32'h100; no stale entry reaches decode.
- `halt` for 4 cycles with `id_ready`=1 → FIFO drains, `id_valid`=0, `rom_addr` constant. `halt` and redirect to 32'h40 together → after `halt` drops, the first `id_pc` is 32'h40.
- `fetch_pc` preloaded (via redirect) to 32'hFFFF_FFF8 → `id_pc` sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `RST_N` pulsed low mid-stream with the FIFO holding 2 entries → `id_valid`=0 and `rom_addr`=`RESET_PC` immediately; the normal boot sequence follows.

Source files
------------

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared widths, state encodings and fetch entry layout
// for the instruction fetch controller and its prefetch FIFO.
package inst_fetch_ctrl_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  localparam logic [DATA_WIDTH-1:0] ZeroWord = '0;

  localparam logic [1:0] FetchBoot = 2'd0;
  localparam logic [1:0] FetchRun  = 2'd1;
  localparam logic [1:0] FetchHalt = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] InstAlignMask = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_BOOT = FetchBoot,
    S_RUN  = FetchRun,
    S_HALT = FetchHalt
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; ports: push/pop/flush,
// wdata in, rdata (head) out, count/full/empty status.
module fetch_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          pop_en;
  logic          push_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_en  = pop & ~empty;
  // a pop frees the slot, so a full FIFO may still take a push
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem[head];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_en) tail <= tail + 1'b1;
      if (pop_en)  head <= head + 1'b1;
      if (push_en && !pop_en)
        count <= count + 1'b1;
      else if (pop_en && !push_en)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_en && !flush) mem[tail] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch controller: owns fetch PC, drives ROM address, queues
// {pc,inst} into prefetch FIFO, drains to decode via valid/ready.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_inst,
  input  logic                  halt,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  id_valid,
  input  logic                  id_ready,
  output logic [DATA_WIDTH-1:0] id_inst,
  output logic [ADDR_WIDTH-1:0] id_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e          state;
  fetch_state_e          state_nxt;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  pop;
  logic                  push_ok;
  fetch_entry_t          wr;
  fetch_entry_t          head;

  assign rom_addr = fetch_pc;
  assign id_valid = (count != '0);
  assign pop      = id_valid & id_ready;

  // id_ready only feeds the tail write enable, never rom_addr
  assign push_ok  = (state == S_RUN) & ~redirect_valid
                  & (~full | pop);

  assign wr.pc    = fetch_pc;
  assign wr.inst  = rom_inst;

  assign id_inst  = empty ? ZeroWord : head.inst;
  assign id_pc    = empty ? '0 : head.pc;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= S_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT:  state_nxt = halt ? S_HALT : S_RUN;
      S_RUN:   state_nxt = halt ? S_HALT : S_RUN;
      S_HALT:  state_nxt = halt ? S_HALT : S_RUN;
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      fetch_pc <= RESET_PC;
    else if (redirect_valid)
      fetch_pc <= redirect_pc & InstAlignMask;
    else if (push_ok)
      fetch_pc <= fetch_pc + 32'd4;
  end

  fetch_fifo #(
    .W     (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_ok),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: queue-based fetch model,
// directed scenarios plus randomized halt/redirect/ready.
module tb_inst_fetch_ctrl;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  always #5 CLK = ~CLK;

  assign rom_inst = 32'h1000_0000 + {2'b00, rom_addr[31:2]};

  inst_fetch_ctrl #(
    .RESET_PC   (RST_PC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc)
  );

  int cmp_n = 0;
  int bad_n = 0;

  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit          m_run;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  function automatic logic [96:0] exp_vec();
    if (q.size() == 0) return {m_pc, 1'b0, 64'h0};
    return {m_pc, 1'b1, q[0]};
  endfunction

  task automatic model_reset();
    q.delete();
    m_pc  = RST_PC;
    m_run = 1'b0;
  endtask

  task automatic tick(input bit h, input bit r,
                      input logic [31:0] rp, input bit rdy);
    bit pop;
    bit push;
    halt = h;
    redirect_valid = r;
    redirect_pc = rp;
    id_ready = rdy;
    @(posedge CLK);
    pop  = (q.size() > 0) && rdy;
    push = m_run && !r && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (r) begin
      q.delete();
      m_pc = rp & 32'hFFFF_FFFC;
    end else if (push) begin
      q.push_back({m_pc, rom_word(m_pc)});
      m_pc = m_pc + 32'd4;
    end
    m_run = !h;
    @(negedge CLK);
  endtask

  task automatic boot_seq(input string tag);
    @(negedge CLK);
    RST_N = 1'b1;
    tick(0, 0, 0, 1);
    cmp_n++;
    if (id_valid !== 1'b0) begin
      bad_n++;
      $display("FAIL %s boot1: id_valid=%b want 0", tag, id_valid);
    end
    tick(0, 0, 0, 1);
    cmp_n++;
    if (id_valid !== 1'b1 || id_pc !== RST_PC
        || id_inst !== 32'h1000_0000) begin
      bad_n++;
      $display("FAIL %s boot2: v=%b pc=%h inst=%h want 1 %h 10000000",
               tag, id_valid, id_pc, id_inst, RST_PC);
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    cmp_n++;
    if ({rom_addr, id_valid, id_pc, id_inst}
        !== {RST_PC, 1'b0, 64'h0}) begin
      bad_n++;
      $display("FAIL reset: addr=%h v=%b pc=%h inst=%h",
               rom_addr, id_valid, id_pc, id_inst);
    end
    boot_seq("reset");
  endtask

  task automatic test_stream();
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, 1);
      cmp_n++;
      if (id_pc !== 32'(4 * (i + 1))
          || {rom_addr, id_valid, id_pc, id_inst} !== exp_vec()) begin
        bad_n++;
        $display("FAIL stream %0d: got %h want %h pc %h",
                 i, {rom_addr, id_valid, id_pc, id_inst},
                 exp_vec(), 32'(4 * (i + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] frozen;
    frozen = '0;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 0);
      if (i == 1) frozen = m_pc;
      cmp_n++;
      if ({rom_addr, id_valid, id_pc, id_inst} !== exp_vec()
          || (i >= 1 && rom_addr !== frozen)) begin
        bad_n++;
        $display("FAIL backpressure %0d: got %h want %h",
                 i, {rom_addr, id_valid, id_pc, id_inst}, exp_vec());
      end
    end
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0, 1);
      cmp_n++;
      if ({rom_addr, id_valid, id_pc, id_inst} !== exp_vec()) begin
        bad_n++;
        $display("FAIL bp_release %0d: got %h want %h",
                 i, {rom_addr, id_valid, id_pc, id_inst}, exp_vec());
      end
    end
  endtask

  task automatic test_redirect();
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    cmp_n++;
    if (q.size() != DEPTH || id_valid !== 1'b1) begin
      bad_n++;
      $display("FAIL redir_fill: v=%b model=%0d", id_valid, q.size());
    end
    tick(0, 1, 32'h0000_0103, 0);
    cmp_n++;
    if (rom_addr !== 32'h100 || id_valid !== 1'b0) begin
      bad_n++;
      $display("FAIL redir_t1: addr=%h v=%b want 100 0",
               rom_addr, id_valid);
    end
    tick(0, 0, 0, 1);
    cmp_n++;
    if (id_valid !== 1'b1 || id_pc !== 32'h100
        || id_inst !== 32'h1000_0040) begin
      bad_n++;
      $display("FAIL redir_t2: v=%b pc=%h inst=%h want 1 100 10000040",
               id_valid, id_pc, id_inst);
    end
  endtask

  task automatic test_halt();
    bit seen;
    for (int i = 0; i < 4; i++) begin
      tick(1, 0, 0, 1);
      cmp_n++;
      if ({rom_addr, id_valid, id_pc, id_inst} !== exp_vec()) begin
        bad_n++;
        $display("FAIL halt %0d: got %h want %h",
                 i, {rom_addr, id_valid, id_pc, id_inst}, exp_vec());
      end
    end
    cmp_n++;
    if (id_valid !== 1'b0) begin
      bad_n++;
      $display("FAIL halt_drain: id_valid=%b want 0", id_valid);
    end
    tick(1, 1, 32'h40, 1);
    tick(1, 0, 0, 1);
    tick(1, 0, 0, 1);
    cmp_n++;
    if (id_valid !== 1'b0 || rom_addr !== 32'h40) begin
      bad_n++;
      $display("FAIL halt_redir: v=%b addr=%h want 0 40",
               id_valid, rom_addr);
    end
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      tick(0, 0, 0, 0);
      if (id_valid === 1'b1) seen = 1'b1;
    end
    cmp_n++;
    if (!seen || id_pc !== 32'h40) begin
      bad_n++;
      $display("FAIL halt_resume: seen=%b pc=%h want 40", seen, id_pc);
    end
    tick(0, 0, 0, 1);
    tick(0, 0, 0, 1);
  endtask

  task automatic test_wrap();
    logic [31:0] want [3];
    want[0] = 32'hFFFF_FFF8;
    want[1] = 32'hFFFF_FFFC;
    want[2] = 32'h0000_0000;
    tick(0, 1, 32'hFFFF_FFF8, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1);
      cmp_n++;
      if (id_valid !== 1'b1 || id_pc !== want[i]) begin
        bad_n++;
        $display("FAIL wrap %0d: v=%b pc=%h want %h",
                 i, id_valid, id_pc, want[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    cmp_n++;
    if (q.size() != DEPTH || id_valid !== 1'b1) begin
      bad_n++;
      $display("FAIL areset_fill: v=%b model=%0d", id_valid, q.size());
    end
    RST_N = 1'b0;
    #1;
    model_reset();
    cmp_n++;
    if (rom_addr !== RST_PC || id_valid !== 1'b0 || id_pc !== 32'h0
        || id_inst !== 32'h0) begin
      bad_n++;
      $display("FAIL areset: addr=%h v=%b pc=%h inst=%h",
               rom_addr, id_valid, id_pc, id_inst);
    end
    boot_seq("areset");
  endtask

  task automatic test_random();
    bit          h;
    bit          r;
    bit          rdy;
    logic [31:0] rp;
    for (int i = 0; i < 300; i++) begin
      h   = ($urandom_range(0, 9) == 0);
      r   = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rp  = $urandom;
      tick(h, r, rp, rdy);
      cmp_n++;
      if ({rom_addr, id_valid, id_pc, id_inst} !== exp_vec()) begin
        bad_n++;
        $display("FAIL random %0d: got %h want %h",
                 i, {rom_addr, id_valid, id_pc, id_inst}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             cmp_n, bad_n);
    $finish;
  end

endmodule
